// File: rtl/ifu_fetch.sv
// RV32 instruction fetch unit: owns the PC, issues one fetch at a time and
// holds the fetched word for the decoder; redirects squash stale fetches.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;

        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        inst_d       = imem_resp_data;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    pc_d         = pc_q + 32'd4;
                    state_d      = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // A redirect overrides every PC update and squashes any data in flight.
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
            unique case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (imem_req_ready) begin
                        drop_d  = 1'b1;
                        state_d = WAIT;
                    end else begin
                        state_d = REQ;
                    end
                end
                WAIT: begin
                    inst_d       = inst_q;
                    inst_pc_d    = inst_pc_q;
                    inst_valid_d = 1'b0;
                    if (imem_resp_valid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = WAIT;
                    end
                end
                HOLD: begin
                    inst_valid_d = 1'b0;
                    state_d      = REQ;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = pc_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign inst_valid     = inst_valid_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: directed scenarios then randomized traffic,
// checked against a PC-stream model and a deterministic memory image.
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    ifu_fetch #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_cons = 0;
    int cyc = 0;
    int acc_cyc = 0;

    int p_rdy = 100;
    int p_ir = 100;
    int p_redir = 0;
    int p_spur = 0;
    int lat_k = 0;
    bit redir_once = 0;
    logic [31:0] redir_tgt = '0;

    logic [31:0] exp_q[$];
    logic [31:0] model_pc = RST_PC;
    logic [31:0] snap_addr = RST_PC;
    bit          snap_busy = 0;
    bit          mem_pending = 0;
    bit          mem_stale = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0050_0093;
        if (a == 32'h8000_0004) return 32'h0010_8113;
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A0F};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Stimulus driver, memory responder and PC-stream reference model.
    initial begin
        exp_q.push_back(RST_PC);
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            imem_req_ready = ($urandom_range(0, 99) < p_rdy);
            inst_ready     = ($urandom_range(0, 99) < p_ir);
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
            if (mem_pending) begin
                if (mem_cnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = memf(mem_addr);
                    mem_pending     = 0;
                    mem_stale       = 0;
                end else begin
                    mem_cnt--;
                end
            end else if ($urandom_range(0, 99) < p_spur) begin
                imem_resp_valid = 1'b1;
            end
            redirect_valid = 1'b0;
            redirect_pc    = $urandom;
            if (redir_once) begin
                redirect_valid = 1'b1;
                redirect_pc    = redir_tgt;
                redir_once     = 0;
            end else if ($urandom_range(0, 99) < p_redir) begin
                redirect_valid = 1'b1;
                if ($urandom_range(0, 3) == 0)
                    redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                else
                    redirect_pc = RST_PC + 32'($urandom_range(0, 4095));
            end

            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                model_pc = RST_PC;
                exp_q.push_back(model_pc);
                snap_addr = model_pc;
                snap_busy = 0;
                if (mem_pending) mem_stale = 1;
            end else begin
                snap_addr = model_pc;
                snap_busy = mem_pending && !mem_stale;
                if (imem_req_valid && imem_req_ready) begin
                    mem_pending = 1;
                    mem_stale   = 0;
                    mem_addr    = imem_req_addr;
                    mem_cnt     = (lat_k < 0) ? $urandom_range(0, 3) : lat_k;
                    acc_cyc     = cyc + 1;
                end
                if (inst_valid && inst_ready) begin
                    model_pc = redirect_valid ? (redirect_pc & ~32'd3)
                                              : model_pc + 32'd4;
                    exp_q.push_back(model_pc);
                end else if (redirect_valid) begin
                    model_pc = redirect_pc & ~32'd3;
                    exp_q.delete();
                    exp_q.push_back(model_pc);
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every consumed instruction.
    initial begin
        bit          prev_hold;
        logic [31:0] prev_inst, prev_pc, e;
        prev_hold = 0;
        prev_inst = '0;
        prev_pc   = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_hold = 0;
            end else begin
                if (imem_req_valid) begin
                    chk("req_addr", imem_req_addr, snap_addr);
                    chk("one_outstanding", 32'(snap_busy), 32'd0);
                end
                if (prev_hold) begin
                    chk("hold_valid", 32'(inst_valid), 32'd1);
                    chk("hold_inst", inst, prev_inst);
                    chk("hold_pc", inst_pc, prev_pc);
                end
                if (inst_valid && inst_ready) begin
                    n_cons++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL sb_empty: got pc %h, none expected", inst_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_pc", inst_pc, e);
                        chk("sb_inst", inst, memf(e));
                    end
                end
                prev_hold = inst_valid && !inst_ready && !redirect_valid;
                prev_inst = inst;
                prev_pc   = inst_pc;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        chk({tag, "_req_addr"}, imem_req_addr, RST_PC);
        chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_inst"}, inst, 32'd0);
        chk({tag, "_inst_pc"}, inst_pc, 32'd0);
    endtask

    initial begin
        int rel;
        int seen;
        logic [31:0] cap_i, cap_p;

        #1 rst = 1'b1;
        #2 chk_reset_outs("rst");
        @(posedge clk);
        #1 rst = 1'b0;
        rel = cyc;

        // Back-to-back fetch latency
        for (int i = 0; i < 10 && !imem_req_valid; i++) step();
        chk("lat_req1_cyc", 32'(cyc - rel), 32'd1);
        chk("lat_req1_addr", imem_req_addr, 32'h8000_0000);
        for (int i = 0; i < 10 && !inst_valid; i++) step();
        chk("lat_inst1_cyc", 32'(cyc - rel), 32'd3);
        chk("lat_inst1", inst, 32'h0050_0093);
        chk("lat_inst1_pc", inst_pc, 32'h8000_0000);
        step();
        for (int i = 0; i < 10 && !imem_req_valid; i++) step();
        chk("lat_req2_cyc", 32'(cyc - rel), 32'd4);
        chk("lat_req2_addr", imem_req_addr, 32'h8000_0004);

        // Decoder backpressure
        p_ir = 0;
        step();
        for (int i = 0; i < 20 && !inst_valid; i++) step();
        chk("bp_valid", 32'(inst_valid), 32'd1);
        cap_i = inst;
        cap_p = inst_pc;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_inst", inst, cap_i);
            chk("bp_pc", inst_pc, cap_p);
            chk("bp_noreq", 32'(imem_req_valid), 32'd0);
            chk("bp_addr", imem_req_addr, cap_p);
        end
        p_ir = 100;
        for (int i = 0; i < 20 && !imem_req_valid; i++) step();
        chk("bp_next_addr", imem_req_addr, cap_p + 32'd4);

        // Memory request stall and slow response
        p_rdy = 0;
        step();
        for (int i = 0; i < 20 && !imem_req_valid; i++) step();
        cap_p = imem_req_addr;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_valid", 32'(imem_req_valid), 32'd1);
            chk("stall_addr", imem_req_addr, cap_p);
        end
        lat_k = 3;
        p_rdy = 100;
        for (int i = 0; i < 20 && !inst_valid; i++) step();
        chk("slow_resp_cyc", 32'(cyc - acc_cyc), 32'd4);
        chk("slow_resp_pc", inst_pc, cap_p);

        // Redirect while waiting for a response
        lat_k = 2;
        for (int i = 0; i < 20 && !(imem_req_valid && imem_req_ready); i++) step();
        redir_tgt  = 32'h8000_0103;
        redir_once = 1;
        seen = 0;
        step();
        for (int i = 0; i < 20 && !imem_req_valid; i++) begin
            if (inst_valid) seen++;
            step();
        end
        chk("rw_no_stale", 32'(seen), 32'd0);
        chk("rw_addr", imem_req_addr, 32'h8000_0100);
        for (int i = 0; i < 20 && !inst_valid; i++) step();
        chk("rw_inst_pc", inst_pc, 32'h8000_0100);

        // Redirect coinciding with consumption in HOLD
        p_ir = 0;
        step();
        for (int i = 0; i < 20 && !inst_valid; i++) step();
        redir_tgt  = 32'h8000_1000;
        redir_once = 1;
        p_ir = 100;
        step();
        for (int i = 0; i < 20 && !imem_req_valid; i++) step();
        chk("rh_addr", imem_req_addr, 32'h8000_1000);
        for (int i = 0; i < 20 && !inst_valid; i++) step();
        chk("rh_inst_pc", inst_pc, 32'h8000_1000);

        // Asynchronous reset in WAIT with a late stale response
        lat_k = 3;
        step();
        for (int i = 0; i < 20 && !(imem_req_valid && imem_req_ready); i++) step();
        p_rdy = 0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_reset_outs("async");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_rst_inst_valid", 32'(inst_valid), 32'd0);
        end
        chk("post_rst_req", 32'(imem_req_valid), 32'd1);
        chk("post_rst_addr", imem_req_addr, RST_PC);
        lat_k = 0;
        p_rdy = 100;
        for (int i = 0; i < 20 && !inst_valid; i++) step();
        chk("post_rst_inst_pc", inst_pc, RST_PC);
        chk("post_rst_inst", inst, 32'h0050_0093);

        // Randomized traffic
        p_rdy   = 70;
        p_ir    = 60;
        p_redir = 8;
        p_spur  = 10;
        lat_k   = -1;
        for (int i = 0; i < 3000; i++) step();
        p_redir = 0;
        p_spur  = 0;
        p_rdy   = 100;
        p_ir    = 100;
        for (int i = 0; i < 50; i++) step();
        n_cmp++;
        if (n_cons < 200) begin
            n_err++;
            $display("FAIL activity: got %0d consumed, expected at least 200", n_cons);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
